// File: rtl/fp_ifarb_pkg.sv
// Shared encodings for the CPU/AWP system-interface arbiter.
package fp_ifarb_pkg;

    localparam int unsigned STATE_W = 2;

    // Arbiter sequencing states
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_REL  = 2'd2
    } ifarb_state_e;

    // Port owner codes
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_FP  = 1'b1
    } ifarb_own_e;

endpackage : fp_ifarb_pkg

// File: rtl/fp_ifarb_timer.sv
// No-answer timer: counts WAIT cycles and flags expiry one cycle before the
// count would reach ALARM_CNT, so the alarm registers exactly ALARM_CNT cycles
// after the grant.
module fp_ifarb_timer #(
    parameter int unsigned ALARM_W   = 8,
    parameter int unsigned ALARM_CNT = 150
) (
    input  logic clk_sys,
    input  logic clm,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [ALARM_W-1:0] cnt;

    // Counter cleared while idle (so it starts at 0 after a grant), advances in WAIT
    always_ff @(posedge clk_sys) begin
        if (clm || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + ALARM_W'(1);
        end
    end

    assign expired_c = en && (cnt == ALARM_W'(ALARM_CNT - 1));

endmodule : fp_ifarb_timer

// File: rtl/fp_ifarb.sv
// Arbiter/sequencer for the single system-interface port shared by CPU and AWP.
// Optional no-answer alarm enabled by defining FPIF_ALARM_EN.
module fp_ifarb
    import fp_ifarb_pkg::*;
#(
    parameter int unsigned ALARM_W   = 8,
    parameter int unsigned ALARM_CNT = 150
) (
    input  logic clk_sys,
    input  logic clm,
    input  logic req_cpu,
    input  logic rd_cpu,
    input  logic req_fp,
    input  logic rd_fp,
    input  logic ok,
    output logic if_req,
    output logic if_rd,
    output logic gnt_cpu,
    output logic gnt_fp,
    output logic done_cpu,
    output logic done_fp,
    output logic alarm,
    output logic busy
);

    ifarb_state_e state;
    ifarb_own_e   owner;
    ifarb_own_e   last_own;

    logic pick_cpu_c;
    logic owner_req_c;
    logic expired_c;

    // Reject a timer limit that cannot be reached by the counter
    if (ALARM_CNT < 2 || ALARM_CNT >= (32'd1 << ALARM_W)) begin : g_bad_cfg
        $error("fp_ifarb: ALARM_CNT out of range for ALARM_W");
    end

    // Round-robin pick: CPU wins alone, or on a tie when AWP owned the port last
    assign pick_cpu_c  = req_cpu && (!req_fp || (last_own == OWN_FP));
    assign owner_req_c = (owner == OWN_CPU) ? req_cpu : req_fp;

`ifdef FPIF_ALARM_EN
    fp_ifarb_timer #(
        .ALARM_W   (ALARM_W),
        .ALARM_CNT (ALARM_CNT)
    ) u_timer (
        .clk_sys   (clk_sys),
        .clm       (clm),
        .clr       (state == S_IDLE),
        .en        (state == S_WAIT),
        .expired_c (expired_c)
    );
`else
    assign expired_c = 1'b0;
`endif

    // Grant / transfer / release sequencer with registered outputs
    always_ff @(posedge clk_sys) begin
        if (clm) begin
            state    <= S_IDLE;
            owner    <= OWN_CPU;
            last_own <= OWN_FP;
            if_req   <= 1'b0;
            if_rd    <= 1'b0;
            gnt_cpu  <= 1'b0;
            gnt_fp   <= 1'b0;
            done_cpu <= 1'b0;
            done_fp  <= 1'b0;
            alarm    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done_cpu <= 1'b0;
            done_fp  <= 1'b0;
            alarm    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_cpu || req_fp) begin
                        state   <= S_WAIT;
                        owner   <= pick_cpu_c ? OWN_CPU : OWN_FP;
                        gnt_cpu <= pick_cpu_c;
                        gnt_fp  <= !pick_cpu_c;
                        if_rd   <= pick_cpu_c ? rd_cpu : rd_fp;
                        if_req  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ok || expired_c) begin
                        state    <= S_REL;
                        if_req   <= 1'b0;
                        done_cpu <= (owner == OWN_CPU);
                        done_fp  <= (owner == OWN_FP);
                        alarm    <= !ok;
                    end
                end
                S_REL: begin
                    if (!owner_req_c) begin
                        state    <= S_IDLE;
                        last_own <= owner;
                        gnt_cpu  <= 1'b0;
                        gnt_fp   <= 1'b0;
                        if_rd    <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    if_req  <= 1'b0;
                    if_rd   <= 1'b0;
                    gnt_cpu <= 1'b0;
                    gnt_fp  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : fp_ifarb

// File: tb/tb_fp_ifarb.sv
// Directed bench for fp_ifarb. Outputs are compared as one packed vector:
// {if_req, if_rd, gnt_cpu, gnt_fp, done_cpu, done_fp, alarm, busy}.
module tb_fp_ifarb;

    logic clk_sys = 1'b0;
    logic clm, req_cpu, rd_cpu, req_fp, rd_fp, ok;
    logic if_req, if_rd, gnt_cpu, gnt_fp, done_cpu, done_fp, alarm, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    fp_ifarb #(
        .ALARM_W   (8),
        .ALARM_CNT (5)
    ) dut (
        .clk_sys  (clk_sys),
        .clm      (clm),
        .req_cpu  (req_cpu),
        .rd_cpu   (rd_cpu),
        .req_fp   (req_fp),
        .rd_fp    (rd_fp),
        .ok       (ok),
        .if_req   (if_req),
        .if_rd    (if_rd),
        .gnt_cpu  (gnt_cpu),
        .gnt_fp   (gnt_fp),
        .done_cpu (done_cpu),
        .done_fp  (done_fp),
        .alarm    (alarm),
        .busy     (busy)
    );

    function automatic logic [7:0] outs();
        return {if_req, if_rd, gnt_cpu, gnt_fp, done_cpu, done_fp, alarm, busy};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        clm = 1'b1; req_cpu = 1'b0; rd_cpu = 1'b0; req_fp = 1'b0; rd_fp = 1'b0; ok = 1'b0;
        step();
        step();
        check("reset", outs(), 8'b0000_0000);
        clm = 1'b0;

        // 1: lone AWP read
        req_fp = 1'b1; rd_fp = 1'b1;
        step();
        check("t1_grant", outs(), 8'b1101_0001);
        step();
        step();
        ok = 1'b1;
        step();
        check("t1_done", outs(), 8'b0101_0101);
        ok = 1'b0;
        step();
        check("t1_rel_hold", outs(), 8'b0101_0001);
        req_fp = 1'b0;
        step();
        check("t1_idle", outs(), 8'b0000_0000);

        // 2: round-robin after reset
        clm = 1'b1;
        step();
        clm = 1'b0;
        req_cpu = 1'b1; rd_cpu = 1'b0; req_fp = 1'b1; rd_fp = 1'b1;
        step();
        check("t2_tie_cpu", outs(), 8'b1010_0001);
        ok = 1'b1;
        step();
        check("t2_cpu_done", outs(), 8'b0010_1001);
        ok = 1'b0; req_cpu = 1'b0;
        step();
        check("t2_rel_no_grant", outs(), 8'b0000_0000);
        step();
        check("t2_fp_grant", outs(), 8'b1101_0001);
        ok = 1'b1;
        step();
        check("t2_fp_done", outs(), 8'b0101_0101);
        ok = 1'b0; req_fp = 1'b0;
        step();
        req_cpu = 1'b1; req_fp = 1'b1;
        step();
        check("t2_tie_cpu_again", outs(), 8'b1010_0001);
        ok = 1'b1;
        step();
        ok = 1'b0; req_cpu = 1'b0; req_fp = 1'b0;
        step();
        check("t2_idle", outs(), 8'b0000_0000);

        // 3: clear during WAIT wins over ok
        req_cpu = 1'b1; rd_cpu = 1'b1;
        step();
        check("t3_grant", outs(), 8'b1110_0001);
        step();
        clm = 1'b1; ok = 1'b1;
        step();
        check("t3_clear", outs(), 8'b0000_0000);
        clm = 1'b0; ok = 1'b0; req_cpu = 1'b0; req_fp = 1'b1; rd_fp = 1'b0;
        step();
        check("t3_idle_regrant", outs(), 8'b1001_0001);
        ok = 1'b1;
        step();
        ok = 1'b0; req_fp = 1'b0;
        step();
        check("t3_idle", outs(), 8'b0000_0000);

        // 5: direction latched, request drop in WAIT ignored
        req_cpu = 1'b1; rd_cpu = 1'b1;
        step();
        check("t5_grant", outs(), 8'b1110_0001);
        rd_cpu = 1'b0; req_cpu = 1'b0;
        step();
        check("t5_hold", outs(), 8'b1110_0001);
        ok = 1'b1;
        step();
        check("t5_done", outs(), 8'b0110_1001);
        ok = 1'b0;
        step();
        check("t5_idle", outs(), 8'b0000_0000);

        // 6: ok outside WAIT has no effect
        ok = 1'b1;
        step();
        check("t6_ok_idle", outs(), 8'b0000_0000);
        ok = 1'b0; req_fp = 1'b1; rd_fp = 1'b0;
        step();
        check("t6_grant", outs(), 8'b1001_0001);
        ok = 1'b1;
        step();
        check("t6_done", outs(), 8'b0001_0101);
        step();
        check("t6_ok_rel", outs(), 8'b0001_0001);
        ok = 1'b0; req_fp = 1'b0;
        step();
        check("t6_idle", outs(), 8'b0000_0000);

`ifdef FPIF_ALARM_EN
        // 4: alarm after ALARM_CNT cycles without ok
        req_cpu = 1'b1; rd_cpu = 1'b0;
        step();
        check("t4_grant", outs(), 8'b1010_0001);
        for (int i = 0; i < 4; i++) step();
        check("t4_pre_alarm", outs(), 8'b1010_0001);
        step();
        check("t4_alarm", outs(), 8'b0010_1011);
        step();
        check("t4_rel", outs(), 8'b0010_0001);
        req_cpu = 1'b0;
        step();
        check("t4_idle", outs(), 8'b0000_0000);
        // ok coincident with expiry: ok wins
        req_cpu = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        ok = 1'b1;
        step();
        check("t4_ok_wins", outs(), 8'b0010_1001);
        ok = 1'b0; req_cpu = 1'b0;
        step();
        check("t4_idle2", outs(), 8'b0000_0000);
`else
        // 6: WAIT persists indefinitely without ok
        req_cpu = 1'b1; rd_cpu = 1'b0;
        step();
        check("t6_wait_grant", outs(), 8'b1010_0001);
        begin
            int bad = 0;
            for (int i = 0; i < 1000; i++) begin
                step();
                if (outs() !== 8'b1010_0001) bad++;
            end
            check("t6_wait_1000_bad", 8'(bad), 8'd0);
        end
        check("t6_wait_1000", outs(), 8'b1010_0001);
        ok = 1'b1;
        step();
        check("t6_wait_done", outs(), 8'b0010_1001);
        ok = 1'b0; req_cpu = 1'b0;
        step();
        check("t6_wait_idle", outs(), 8'b0000_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fp_ifarb
